median_last_actor: RTL and testbench
====================================

// Module: median_last_actor
// PURPOSE
//  Final median-filter stage, directly downstream of the first/iterating fill-and-check actors.
//  Per frame: consumes one token set (pivot, buff_size, median_pos, second_median_value), then buff_size pixels.
//  Resolves the pixel of rank median_pos (0-based, ascending) in the residual buffer.
//  Emits one 8-bit median token per frame.
// PARAMETERS
//  BUFF_SIZE      8                       max residual pixels per frame (storage depth)
//  BUFF_SIZE_BIT  $clog2(BUFF_SIZE)+1     width of size/position tokens; must match upstream
// PORTS
//  clock                    in   1        system clock
//  reset                    in   1        synchronous, active-high
//  in_px                    in   8        pixel stream, FWFT FIFO data
//  in_px_rd                 out  1        pixel pop; only asserted when ~in_px_empty
//  in_px_empty              in   1        pixel FIFO empty
//  in_pivot / _rd / _empty              8/1/1    pivot token FIFO (same handshake)
//  in_buff_size / _rd / _empty          BSB/1/1  residual buffer size token FIFO
//  in_median_pos / _rd / _empty         BSB/1/1  target rank token FIFO
//  in_second_median_value / _rd / _empty 8/1/1   pre-resolved value token FIFO
//  out_median               out  8        result token
//  out_median_wr            out  1        one-cycle push; only asserted when ~out_median_full
//  out_median_full          in   1        downstream FIFO full
// BEHAVIOUR
//  Reset: all *_rd=0, out_median_wr=0, out_median=0, counters cleared, state=IDLE.
//   Reset wins over every other event, including mid-FILL/SCAN. Partial frame is dropped.
//  Handshake: FWFT. A word is consumed on the cycle rd=1 and empty=0. Data is valid in that same cycle.
//  FSM:
//   IDLE   - wait until all four token FIFOs are non-empty -> SAMPLE.
//   SAMPLE - assert all four token rd for exactly 1 cycle; latch tokens.
//            pos_eff = min(median_pos, buff_size-1).
//            buff_size > BUFF_SIZE is clamped to BUFF_SIZE.
//            buff_size==0 -> OUT with result=second_median_value; no pixels read. Otherwise -> FILL.
//   FILL   - in_px_rd = ~in_px_empty while wr_idx < n. Each popped px is written to buf[wr_idx].
//            Also updates cnt_lt (px < pivot) and cnt_eq (px == pivot).
//            Empty gaps stall without side effects. Last pop -> CHECK.
//   CHECK  - 1 cycle. If cnt_lt <= pos_eff < cnt_lt+cnt_eq: result=pivot -> OUT. Else cand=0 -> SCAN.
//   SCAN   - for candidate buf[cand], take n cycles over j and count lt/eq against buf[cand].
//            Then 1 evaluate cycle: if lt <= pos_eff < lt+eq, result=buf[cand] -> OUT; else cand++.
//            A hit is guaranteed by cand=n-1.
//   OUT    - hold out_median=result. Assert out_median_wr for 1 cycle once ~out_median_full. -> IDLE.
//            While full: wr=0, data held, no input consumed.
//  Latency, from last px pop to wr (downstream not full):
//   pivot hit: 2 cycles.
//   scan: 2 + (k+1)*(n+1) cycles, where k = index of the first matching candidate.
//   buff_size==0: SAMPLE->OUT, 2 cycles after tokens are available.
//  Widths: counters are BUFF_SIZE_BIT wide; cnt_lt+cnt_eq is computed at BUFF_SIZE_BIT+1 (no wrap).
//   Compares are unsigned.
//  Back-to-back frames: IDLE is re-entered the cycle after wr. The next token set may sample the following cycle.
//  Pixel over-supply: extra px beyond n are never popped by this frame; they belong to the next frame.
// STRUCTURE
//  Shared package median_pkg: FSM state encoding, PX_W=8, DEFAULT_PIVOT=8'd127, rank-window compare function.
//  One sub-module, median_rank_scan:
//   buffer RAM + j counter + lt/eq accumulators vs a reference value.
//   Reused for CHECK (ref=pivot, fed live during FILL) and SCAN (ref=buf[cand]).
//  Top holds FSM, token latches and handshakes.
// TESTING (BUFF_SIZE=8)
//  1. buff_size=0, second=42, pos=3 -> out_median=42 after 2 cycles; in_px_rd never asserted.
//  2. pivot=100, px{10,100,200,100,50}, size=5, pos=2 -> lt=2, eq=2, hit -> 100.
//     wr exactly 2 cycles after the 5th pop.
//  3. pivot=127, px{9,3,7,1}, size=4, pos=1 -> pivot miss, SCAN -> 3 (candidate index 1).
//     wr 12 cycles after last pop.
//  4. Case 2 with out_median_full=1 for 10 cycles -> wr stays 0, out_median=100 held;
//     single wr after full drops; next frame's tokens not popped meanwhile.
//  5. px FIFO empty every other cycle during FILL of case 3 -> same result 3.
//     Then reset pulsed mid-SCAN of a repeat -> outputs 0, IDLE; following frame resolves correctly.
//  6. size=8, all px=255, pivot=127, pos=9 -> pos clamped to 7 -> 255.
//     Immediately followed by case 2 -> two wr pulses with values 255, 100.

Source files
------------

// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
//   Shared definitions for the final median-filter stage:
//     PX_W          pixel / value width
//     DEFAULT_PIVOT nominal pivot value used by the upstream actors
//     state_t       FSM encoding of median_last_actor
//     rank_hit()    rank-window test: lt <= pos < lt + eq
// ---------------------------------------------------------------------------
package median_pkg;

  localparam int PX_W = 8;
  localparam logic [PX_W-1:0] DEFAULT_PIVOT = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_FILL,
    ST_CHECK,
    ST_SCAN,
    ST_EVAL,
    ST_OUT
  } state_t;

  // Operands are widened to 32 bits so lt + eq can never wrap.
  function automatic logic rank_hit(input int unsigned lt,
                                    input int unsigned eq,
                                    input int unsigned pos);
    return (lt <= pos) && (pos < lt + eq);
  endfunction

endpackage

// File: rtl/median_rank_scan.sv
// ---------------------------------------------------------------------------
// median_rank_scan
//   Residual pixel buffer plus a walking index j and lt/eq accumulators that
//   count how many compared pixels are below / equal to a reference value.
//   Ports:
//     clock, reset   clock, synchronous active-high reset (control only)
//     clr            zero j, cnt_lt, cnt_eq
//     fill_en        write fill_px to buf[j], compare it to ref_px, j++
//     fill_px        incoming pixel
//     scan_en        compare buf[j] to ref_px, j++
//     ref_px         reference value for the compare
//     cand_idx       buffer index whose value is presented on cand_px
//     j              current buffer index
//     cand_px        buf[cand_idx]
//     cnt_lt/cnt_eq  accumulated below / equal counts
// ---------------------------------------------------------------------------
module median_rank_scan
  import median_pkg::*;
#(
  parameter int BUFF_SIZE     = 8,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int IDX_W         = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     fill_en,
  input  logic [PX_W-1:0]          fill_px,
  input  logic                     scan_en,
  input  logic [PX_W-1:0]          ref_px,
  input  logic [IDX_W-1:0]         cand_idx,
  output logic [IDX_W-1:0]         j,
  output logic [PX_W-1:0]          cand_px,
  output logic [BUFF_SIZE_BIT-1:0] cnt_lt,
  output logic [BUFF_SIZE_BIT-1:0] cnt_eq
);

  logic [PX_W-1:0]          mem_q [BUFF_SIZE];
  logic [IDX_W-1:0]         j_q, j_d;
  logic [BUFF_SIZE_BIT-1:0] lt_q, lt_d, eq_q, eq_d;
  logic [PX_W-1:0]          cmp_px;
  logic                     acc_en;

  assign j       = j_q;
  assign cnt_lt  = lt_q;
  assign cnt_eq  = eq_q;
  assign cand_px = mem_q[cand_idx];

  // While filling, the live pixel is compared (against the pivot) in the
  // same cycle it is stored, so the pivot check needs no extra pass.
  always_comb begin
    acc_en = fill_en | scan_en;
    cmp_px = fill_en ? fill_px : mem_q[j_q];
    j_d    = j_q;
    lt_d   = lt_q;
    eq_d   = eq_q;
    if (clr) begin
      j_d  = '0;
      lt_d = '0;
      eq_d = '0;
    end else if (acc_en) begin
      j_d = j_q + 1'b1;
      if (cmp_px < ref_px)  lt_d = lt_q + 1'b1;
      if (cmp_px == ref_px) eq_d = eq_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      j_q  <= '0;
      lt_q <= '0;
      eq_q <= '0;
    end else begin
      j_q  <= j_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
    if (fill_en) mem_q[j_q] <= fill_px;
  end

endmodule

// File: rtl/median_last_actor.sv
// ---------------------------------------------------------------------------
// median_last_actor
//   Final median-filter stage. Per frame it pops one token set (pivot,
//   buff_size, median_pos, second_median_value), then buff_size pixels, and
//   emits the pixel of rank median_pos (0-based ascending) as one token.
//   Ports (all FIFOs first-word-fall-through, word consumed when rd & ~empty):
//     clock, reset                       clock, synchronous active-high reset
//     in_px / _rd / _empty               pixel stream
//     in_pivot / _rd / _empty            pivot token
//     in_buff_size / _rd / _empty        residual buffer size token
//     in_median_pos / _rd / _empty       target rank token
//     in_second_median_value / _rd / _empty  value used when buffer is empty
//     out_median / _wr / _full           result token push
// ---------------------------------------------------------------------------
module median_last_actor
  import median_pkg::*;
#(
  parameter int BUFF_SIZE     = 8,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PX_W-1:0]          in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  input  logic [PX_W-1:0]          in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [PX_W-1:0]          in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,
  output logic [PX_W-1:0]          out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full
);

  localparam int IDX_W = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
  localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

  state_t                   state_q, state_d;
  logic [PX_W-1:0]          pivot_q, pivot_d;
  logic [PX_W-1:0]          result_q, result_d;
  logic [BUFF_SIZE_BIT-1:0] n_q, n_d, pos_q, pos_d;
  logic [IDX_W-1:0]         cand_q, cand_d;

  logic                     tok_avail, tok_rd, px_pop, hit;
  logic                     rs_clr, rs_scan;
  logic [PX_W-1:0]          rs_ref, cand_px;
  logic [IDX_W-1:0]         rs_j;
  logic [BUFF_SIZE_BIT-1:0] cnt_lt, cnt_eq, size_eff, last_idx;

  assign tok_avail = ~in_pivot_empty & ~in_buff_size_empty &
                     ~in_median_pos_empty & ~in_second_median_value_empty;

  // IDLE only leaves when every token FIFO is non-empty, so SAMPLE can pop
  // all four unconditionally.
  assign tok_rd                    = (state_q == ST_SAMPLE);
  assign in_pivot_rd               = tok_rd;
  assign in_buff_size_rd           = tok_rd;
  assign in_median_pos_rd          = tok_rd;
  assign in_second_median_value_rd = tok_rd;

  assign px_pop        = (state_q == ST_FILL) & ~in_px_empty;
  assign in_px_rd      = px_pop;
  assign out_median    = result_q;
  assign out_median_wr = (state_q == ST_OUT) & ~out_median_full;

  assign size_eff = (in_buff_size > SIZE_MAX) ? SIZE_MAX : in_buff_size;
  assign last_idx = n_q - ONE;
  assign hit      = rank_hit(32'(cnt_lt), 32'(cnt_eq), 32'(pos_q));
  assign rs_ref   = (state_q == ST_FILL) ? pivot_q : cand_px;
  assign rs_scan  = (state_q == ST_SCAN);

  median_rank_scan #(
    .BUFF_SIZE    (BUFF_SIZE),
    .BUFF_SIZE_BIT(BUFF_SIZE_BIT),
    .IDX_W        (IDX_W)
  ) u_rank_scan (
    .clock   (clock),
    .reset   (reset),
    .clr     (rs_clr),
    .fill_en (px_pop),
    .fill_px (in_px),
    .scan_en (rs_scan),
    .ref_px  (rs_ref),
    .cand_idx(cand_q),
    .j       (rs_j),
    .cand_px (cand_px),
    .cnt_lt  (cnt_lt),
    .cnt_eq  (cnt_eq)
  );

  always_comb begin
    state_d  = state_q;
    pivot_d  = pivot_q;
    result_d = result_q;
    n_d      = n_q;
    pos_d    = pos_q;
    cand_d   = cand_q;
    rs_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (tok_avail) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        pivot_d = in_pivot;
        n_d     = size_eff;
        pos_d   = (in_median_pos > size_eff - ONE) ? size_eff - ONE : in_median_pos;
        rs_clr  = 1'b1;
        if (size_eff == '0) begin
          result_d = in_second_median_value;
          state_d  = ST_OUT;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: if (px_pop && (BUFF_SIZE_BIT'(rs_j) == last_idx)) state_d = ST_CHECK;
      ST_CHECK: begin
        rs_clr = 1'b1;
        cand_d = '0;
        if (hit) begin
          result_d = pivot_q;
          state_d  = ST_OUT;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: if (BUFF_SIZE_BIT'(rs_j) == last_idx) state_d = ST_EVAL;
      ST_EVAL: begin
        rs_clr = 1'b1;
        // The last candidate always satisfies the window; the index test
        // only bounds the loop.
        if (hit || (BUFF_SIZE_BIT'(cand_q) == last_idx)) begin
          result_d = cand_px;
          state_d  = ST_OUT;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_OUT: if (~out_median_full) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      n_q      <= '0;
      pos_q    <= '0;
      cand_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      n_q      <= n_d;
      pos_q    <= pos_d;
      cand_q   <= cand_d;
    end
    pivot_q <= pivot_d;
  end

endmodule

// File: tb/tb_median_last_actor.sv
// ---------------------------------------------------------------------------
// tb_median_last_actor
//   Scoreboard bench: each issued frame pushes its expected median (and
//   expected latency) computed by a sort-based reference model; a monitor
//   pops and compares on every out_median_wr. Upstream FIFOs and the
//   downstream full flag are modelled by one driver process.
// ---------------------------------------------------------------------------
module tb_median_last_actor;
  import median_pkg::*;

  localparam int BUFF_SIZE = 8;
  localparam int BSB       = $clog2(BUFF_SIZE) + 1;

  typedef logic [7:0] px_t;
  typedef struct {
    px_t val;
    int  lat;
    bit  from_px;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  px_t in_px, in_pivot, in_second_median_value, out_median;
  logic [BSB-1:0] in_buff_size, in_median_pos;
  logic in_px_rd, in_px_empty, in_pivot_rd, in_pivot_empty;
  logic in_buff_size_rd, in_buff_size_empty, in_median_pos_rd, in_median_pos_empty;
  logic in_second_median_value_rd, in_second_median_value_empty;
  logic out_median_wr, out_median_full;

  always #5 clock = ~clock;

  median_last_actor #(.BUFF_SIZE(BUFF_SIZE), .BUFF_SIZE_BIT(BSB)) dut (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
    .in_pivot(in_pivot), .in_pivot_rd(in_pivot_rd), .in_pivot_empty(in_pivot_empty),
    .in_buff_size(in_buff_size), .in_buff_size_rd(in_buff_size_rd),
    .in_buff_size_empty(in_buff_size_empty),
    .in_median_pos(in_median_pos), .in_median_pos_rd(in_median_pos_rd),
    .in_median_pos_empty(in_median_pos_empty),
    .in_second_median_value(in_second_median_value),
    .in_second_median_value_rd(in_second_median_value_rd),
    .in_second_median_value_empty(in_second_median_value_empty),
    .out_median(out_median), .out_median_wr(out_median_wr),
    .out_median_full(out_median_full)
  );

  px_t px_f[$], pivot_f[$], second_f[$];
  logic [BSB-1:0] size_f[$], pos_f[$];
  exp_t sb[$];
  int wr_log[$], tok_log[$], pxw_log[$];

  int cyc = 0, n_cmp = 0, n_err = 0, viol = 0;
  int px_pops = 0, tok_pops = 0, last_px_pop_cyc = 0, last_tok_pop_cyc = 0;
  bit gap_alt = 0, gap_rand = 0, full_force = 0, full_rand = 0;
  bit px_hold = 0, full_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic refresh();
    in_px_empty = (px_f.size() == 0) || px_hold;
    in_px       = (px_f.size() != 0) ? px_f[0] : '0;
    in_pivot_empty = (pivot_f.size() == 0);
    in_pivot       = (pivot_f.size() != 0) ? pivot_f[0] : '0;
    in_buff_size_empty = (size_f.size() == 0);
    in_buff_size       = (size_f.size() != 0) ? size_f[0] : '0;
    in_median_pos_empty = (pos_f.size() == 0);
    in_median_pos       = (pos_f.size() != 0) ? pos_f[0] : '0;
    in_second_median_value_empty = (second_f.size() == 0);
    in_second_median_value       = (second_f.size() != 0) ? second_f[0] : '0;
  endtask

  // FIFO / downstream driver: pops decided mid-cycle, applied just after the edge.
  initial begin
    bit pop_px, pop_tok;
    out_median_full = 1'b0;
    refresh();
    forever begin
      @(negedge clock);
      pop_px  = in_px_rd && !in_px_empty;
      pop_tok = in_pivot_rd && !in_pivot_empty;
      if (in_px_rd && in_px_empty) viol++;
      if (in_pivot_rd && (in_pivot_empty || in_buff_size_empty ||
                          in_median_pos_empty || in_second_median_value_empty)) viol++;
      if ((in_pivot_rd != in_buff_size_rd) || (in_pivot_rd != in_median_pos_rd) ||
          (in_pivot_rd != in_second_median_value_rd)) viol++;
      if (pop_px) begin px_pops++; last_px_pop_cyc = cyc; end
      if (pop_tok) begin tok_pops++; last_tok_pop_cyc = cyc; tok_log.push_back(cyc); end
      @(posedge clock);
      #1;
      if (pop_px) void'(px_f.pop_front());
      if (pop_tok) begin
        void'(pivot_f.pop_front());
        void'(size_f.pop_front());
        void'(pos_f.pop_front());
        void'(second_f.pop_front());
      end
      px_hold = gap_alt ? !px_hold : (gap_rand ? ($urandom_range(0, 2) == 0) : 1'b0);
      out_median_full = full_force || (full_rand && ($urandom_range(0, 3) == 0));
      refresh();
    end
  end

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (out_median_wr) begin
        exp_t e;
        wr_log.push_back(cyc);
        pxw_log.push_back(px_pops);
        if (out_median_full) begin
          n_cmp++; n_err++;
          $display("FAIL wr_while_full: got wr=1 required wr=0");
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_wr: got %0d required no output", out_median);
        end else begin
          e = sb.pop_front();
          if (out_median !== e.val) begin
            n_err++;
            $display("FAIL median_value: got %0d required %0d", out_median, e.val);
          end
          if (!full_seen)
            check("latency", cyc - (e.from_px ? last_px_pop_cyc : last_tok_pop_cyc), e.lat);
        end
        full_seen = 0;
      end else if (out_median_full) begin
        full_seen = 1;
      end
    end
  end

  // Reference: clamp, sort, pick rank; latency from the first buffer index
  // holding the answer.
  function automatic exp_t model(input px_t pivot, input int size, input int pos,
                                 input px_t second, input px_t px[$]);
    exp_t e;
    int n, p, k;
    px_t s[$];
    n = (size > BUFF_SIZE) ? BUFF_SIZE : size;
    if (n == 0) begin
      e.val = second; e.lat = 1; e.from_px = 0;
      return e;
    end
    p = (pos > n - 1) ? n - 1 : pos;
    for (int i = 0; i < n; i++) s.push_back(px[i]);
    s.sort();
    e.val = s[p];
    e.from_px = 1;
    if (e.val == pivot) e.lat = 2;
    else begin
      k = 0;
      while (px[k] != e.val) k++;
      e.lat = 2 + (k + 1) * (n + 1);
    end
    return e;
  endfunction

  task automatic send_frame(input px_t pivot, input int size, input int pos,
                            input px_t second, input px_t px[$], input bit expect_out);
    int n;
    n = (size > BUFF_SIZE) ? BUFF_SIZE : size;
    for (int i = 0; i < n; i++) px_f.push_back(px[i]);
    pivot_f.push_back(pivot);
    size_f.push_back(BSB'(size));
    pos_f.push_back(BSB'(pos));
    second_f.push_back(second);
    if (expect_out) sb.push_back(model(pivot, size, pos, second, px));
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin @(negedge clock); k++; end
    @(negedge clock);
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic int log_at(input int q[$], input int idx);
    return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    px_t c2[$], c3[$], v[$], w[$];
    int wb, pxb, ta, k, n;
    c2 = {8'd10, 8'd100, 8'd200, 8'd100, 8'd50};
    c3 = {8'd9, 8'd3, 8'd7, 8'd1};

    repeat (3) @(negedge clock);
    check("rst_out_median", int'(out_median), 0);
    check("rst_wr", int'(out_median_wr), 0);
    check("rst_px_rd", int'(in_px_rd), 0);
    check("rst_tok_rd", int'(in_pivot_rd), 0);
    reset = 1'b0;

    // Empty buffer followed by the pivot-hit frame; no pixel may move for the first.
    @(negedge clock);
    wb = wr_log.size(); pxb = px_pops;
    v = {};
    send_frame(DEFAULT_PIVOT, 0, 3, 8'd42, v, 1);
    send_frame(8'd100, 5, 2, 8'd0, c2, 1);
    drain("t12", 200);
    check("t1_px_pops_at_wr", log_at(pxw_log, wb) - pxb, 0);
    check("t2_px_pops_at_wr", log_at(pxw_log, wb + 1) - pxb, 5);

    // Downstream full holds the result; next frame tokens wait.
    full_force = 1;
    wb = wr_log.size();
    send_frame(8'd100, 5, 2, 8'd0, c2, 1);
    send_frame(8'd127, 4, 1, 8'd0, c3, 1);
    repeat (14) @(negedge clock);
    ta = tok_pops;
    repeat (10) @(negedge clock);
    check("t4_held_value", int'(out_median), 100);
    check("t4_tokens_held", tok_pops - ta, 0);
    check("t4_no_wr_while_full", wr_log.size() - wb, 0);
    full_force = 0;
    drain("t4", 300);
    check("t4_wr_count", wr_log.size() - wb, 2);

    // Gapped pixel stream, then reset in the middle of a scan.
    gap_alt = 1;
    send_frame(8'd127, 4, 1, 8'd0, c3, 1);
    drain("t5a", 300);
    gap_alt = 0;
    @(negedge clock);
    pxb = px_pops;
    send_frame(8'd127, 4, 1, 8'd0, c3, 0);
    k = 0;
    while (px_pops < pxb + 4 && k < 100) begin @(negedge clock); k++; end
    check("t5_fill_done", px_pops - pxb, 4);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_out_median", int'(out_median), 0);
    check("t5_rst_wr", int'(out_median_wr), 0);
    check("t5_rst_px_rd", int'(in_px_rd), 0);
    check("t5_rst_tok_rd", int'(in_pivot_rd), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    send_frame(8'd100, 5, 2, 8'd0, c2, 1);
    drain("t5b", 300);

    // Clamped rank then back-to-back pivot-hit frame.
    v = {};
    for (int i = 0; i < 8; i++) v.push_back(8'd255);
    wb = wr_log.size();
    send_frame(8'd127, 8, 9, 8'd0, v, 1);
    send_frame(8'd100, 5, 2, 8'd0, c2, 1);
    drain("t6", 400);
    check("t6_wr_count", wr_log.size() - wb, 2);
    check("t6_next_sample_gap",
          log_at(tok_log, tok_log.size() - 1) - log_at(wr_log, wr_log.size() - 2), 2);

    // Randomized frames with random gaps and backpressure.
    gap_rand = 1; full_rand = 1;
    for (int f = 0; f < 40; f++) begin
      int size, pos;
      px_t pv;
      size = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
      pos  = $urandom_range(0, 12);
      n = (size > BUFF_SIZE) ? BUFF_SIZE : size;
      w = {};
      for (int i = 0; i < n; i++) w.push_back(px_t'($urandom_range(0, 5) * 50));
      if (n > 0 && $urandom_range(0, 1) == 1) pv = w[$urandom_range(0, n - 1)];
      else pv = px_t'($urandom_range(0, 5) * 50);
      @(negedge clock);
      send_frame(pv, size, pos, px_t'($urandom_range(0, 255)), w, 1);
    end
    drain("random", 12000);
    gap_rand = 0; full_rand = 0;

    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
